iccm_port_arbiter: RTL

- Shares the single ICCM SRAM port (instr_mem_top) between two requesters: port 0 is the instruction-fetch SRAM adapter, port 1 is the program loader (debug/UART boot path).
- Round-robin arbitration in normal operation.
- An exclusive-lock sequence lets the loader drain fetch traffic and then own the memory for programming.
- Tracks outstanding reads and routes each read response back to the requester that issued it.

---
 rtl/iccm_port_arbiter.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/iccm_port_arbiter.sv
// ICCM port arbiter: shares the single ICCM SRAM port between the fetch
// adapter (port 0) and the program loader (port 1). Round-robin in normal
// operation, an exclusive-lock sequence for the loader, and an owner FIFO
// that steers each in-order read response back to the port that issued it.
module iccm_port_arbiter #(
    parameter int AW             = 12,
    parameter int DW             = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          p0_req_i,
    input  logic          p0_we_i,
    input  logic [AW-1:0] p0_addr_i,
    input  logic [DW-1:0] p0_wdata_i,
    input  logic [DW-1:0] p0_wmask_i,
    output logic          p0_gnt_o,
    output logic          p0_rvalid_o,

    input  logic          p1_req_i,
    input  logic          p1_we_i,
    input  logic [AW-1:0] p1_addr_i,
    input  logic [DW-1:0] p1_wdata_i,
    input  logic [DW-1:0] p1_wmask_i,
    output logic          p1_gnt_o,
    output logic          p1_rvalid_o,

    output logic [DW-1:0] p_rdata_o,

    input  logic          lock_i,
    output logic          lock_ack_o,

    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic [DW-1:0] mem_wmask_o,
    input  logic          mem_gnt_i,
    input  logic          mem_rvalid_i,
    input  logic [DW-1:0] mem_rdata_i,

    output logic          resp_err_o
);

    // A depth-1 FIFO still needs a one-bit pointer.
    localparam int PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CW = $clog2(MaxOutstanding + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MaxOutstanding);
    localparam logic [PW-1:0] LAST_PTR = PW'(MaxOutstanding - 1);

    typedef enum logic [1:0] {
        ST_SHARED = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e          state_r;
    logic            lock_ack_r;
    logic            prio_r;      // port preferred when both are eligible
    logic            err_r;

    logic            fifo_r [MaxOutstanding];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    logic            full_s;
    logic            empty_s;
    logic            p0_elig_s;
    logic            p1_elig_s;
    logic            sel0_s;
    logic            sel1_s;
    logic            gnt0_s;
    logic            gnt1_s;
    logic            push_s;
    logic            pop_s;
    logic            head_s;
    logic [CW-1:0]   cnt_next_s;

    logic            mem_req_s;
    logic            mem_we_s;
    logic [AW-1:0]   mem_addr_s;
    logic [DW-1:0]   mem_wdata_s;
    logic [DW-1:0]   mem_wmask_s;

    // Pointer advance with explicit wrap at the FIFO depth.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? {PW{1'b0}} : ptr + PW'(1);
    endfunction

    // Reads need a free owner slot; writes never produce a response.
    // Combinational outputs are forced quiet while reset is asserted.
    assign full_s    = (count_r == FULL_CNT);
    assign empty_s   = (count_r == {CW{1'b0}});
    assign p0_elig_s = rst_ni & p0_req_i & (p0_we_i | ~full_s) &
                       (state_r == ST_SHARED);
    assign p1_elig_s = rst_ni & p1_req_i & (p1_we_i | ~full_s) &
                       ((state_r == ST_SHARED) | (state_r == ST_LOCKED));

    // Round-robin choice between the eligible requesters.
    always_comb begin
        sel0_s = 1'b0;
        sel1_s = 1'b0;
        if (p0_elig_s && p1_elig_s) begin
            sel0_s = ~prio_r;
            sel1_s = prio_r;
        end else begin
            sel0_s = p0_elig_s;
            sel1_s = p1_elig_s;
        end
    end

    // Memory request fields follow the selected port; idle port is all-zero.
    always_comb begin
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = {AW{1'b0}};
        mem_wdata_s = {DW{1'b0}};
        mem_wmask_s = {DW{1'b0}};
        if (sel0_s) begin
            mem_req_s   = 1'b1;
            mem_we_s    = p0_we_i;
            mem_addr_s  = p0_addr_i;
            mem_wdata_s = p0_wdata_i;
            mem_wmask_s = p0_wmask_i;
        end else if (sel1_s) begin
            mem_req_s   = 1'b1;
            mem_we_s    = p1_we_i;
            mem_addr_s  = p1_addr_i;
            mem_wdata_s = p1_wdata_i;
            mem_wmask_s = p1_wmask_i;
        end else begin
            mem_req_s   = 1'b0;
        end
    end

    assign gnt0_s = sel0_s & mem_gnt_i;
    assign gnt1_s = sel1_s & mem_gnt_i;
    assign push_s = (gnt0_s & ~p0_we_i) | (gnt1_s & ~p1_we_i);
    assign pop_s  = rst_ni & mem_rvalid_i & ~empty_s;
    assign head_s = fifo_r[rd_ptr_r];

    // Occupancy after this cycle's push/pop, also used for the drain exit.
    always_comb begin
        cnt_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   cnt_next_s = count_r + CW'(1);
            2'b01:   cnt_next_s = count_r - CW'(1);
            default: cnt_next_s = count_r;
        endcase
    end

    // Lock sequencing FSM; lock_ack is high exactly while LOCKED.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_SHARED;
            lock_ack_r <= 1'b0;
        end else begin
            case (state_r)
                ST_SHARED: begin
                    state_r    <= lock_i ? ST_DRAIN : ST_SHARED;
                    lock_ack_r <= 1'b0;
                end
                ST_DRAIN: begin
                    if (!lock_i) begin
                        state_r    <= ST_SHARED;
                        lock_ack_r <= 1'b0;
                    end else if (cnt_next_s == {CW{1'b0}}) begin
                        state_r    <= ST_LOCKED;
                        lock_ack_r <= 1'b1;
                    end else begin
                        state_r    <= ST_DRAIN;
                        lock_ack_r <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (!lock_i) begin
                        state_r    <= ST_SHARED;
                        lock_ack_r <= 1'b0;
                    end else begin
                        state_r    <= ST_LOCKED;
                        lock_ack_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_SHARED;
                    lock_ack_r <= 1'b0;
                end
            endcase
        end
    end

    // Round-robin pointer moves only when a grant actually happens.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_r <= 1'b0;
        end else if (gnt0_s) begin
            prio_r <= 1'b1;
        end else if (gnt1_s) begin
            prio_r <= 1'b0;
        end else begin
            prio_r <= prio_r;
        end
    end

    // Owner FIFO: records which port issued each read still in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MaxOutstanding; i++) begin
                fifo_r[i] <= 1'b0;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= gnt1_s;
                wr_ptr_r         <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= cnt_next_s;
        end
    end

    // Sticky flag for a response that has no matching outstanding read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_r <= 1'b0;
        end else if (mem_rvalid_i && empty_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign p0_gnt_o    = gnt0_s;
    assign p1_gnt_o    = gnt1_s;
    assign p0_rvalid_o = pop_s & ~head_s;
    assign p1_rvalid_o = pop_s & head_s;
    assign p_rdata_o   = (rst_ni && mem_rvalid_i) ? mem_rdata_i : {DW{1'b0}};
    assign lock_ack_o  = lock_ack_r;
    assign resp_err_o  = err_r;
    assign mem_req_o   = mem_req_s;
    assign mem_we_o    = mem_we_s;
    assign mem_addr_o  = mem_addr_s;
    assign mem_wdata_o = mem_wdata_s;
    assign mem_wmask_o = mem_wmask_s;

endmodule
